// File: rtl/frame_scheduler.sv
// Frame scheduler: walks the screen in raster order and hands each pixel to an
// idle iteration engine chosen round-robin, honouring downstream backpressure.
module frame_scheduler #(
    parameter int PIXEL_DATA_WIDTH  = 10,
    parameter int ENGINE_DATA_WIDTH = 25,
    parameter int SCREEN_WIDTH      = 640,
    parameter int SCREEN_HEIGHT     = 480,
    parameter int NUM_ENGINES       = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                frame_start,
    input  logic signed [ENGINE_DATA_WIDTH-1:0] x_offset_in,
    input  logic signed [ENGINE_DATA_WIDTH-1:0] y_offset_in,
    input  logic                                full_queue,
    input  logic        [NUM_ENGINES-1:0]       engine_idle,
    output logic                                pix_valid,
    output logic        [PIXEL_DATA_WIDTH-1:0]  pixel_x,
    output logic        [PIXEL_DATA_WIDTH-1:0]  pixel_y,
    output logic        [NUM_ENGINES-1:0]       engine_sel,
    output logic signed [ENGINE_DATA_WIDTH-1:0] x_offset,
    output logic signed [ENGINE_DATA_WIDTH-1:0] y_offset,
    output logic                                busy,
    output logic                                frame_done
);

    localparam int PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam logic [PIXEL_DATA_WIDTH-1:0] X_LAST = PIXEL_DATA_WIDTH'(SCREEN_WIDTH - 1);
    localparam logic [PIXEL_DATA_WIDTH-1:0] Y_LAST = PIXEL_DATA_WIDTH'(SCREEN_HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                                r_state;
    logic        [PIXEL_DATA_WIDTH-1:0]    r_scan_x;
    logic        [PIXEL_DATA_WIDTH-1:0]    r_scan_y;
    logic        [PTR_W-1:0]               r_rr_ptr;
    logic                                  r_pix_valid;
    logic        [PIXEL_DATA_WIDTH-1:0]    r_pixel_x;
    logic        [PIXEL_DATA_WIDTH-1:0]    r_pixel_y;
    logic        [NUM_ENGINES-1:0]         r_engine_sel;
    logic signed [ENGINE_DATA_WIDTH-1:0]   r_x_offset;
    logic signed [ENGINE_DATA_WIDTH-1:0]   r_y_offset;
    logic                                  r_busy;
    logic                                  r_frame_done;

    logic        [NUM_ENGINES-1:0]         w_eligible;
    logic                                  w_found;
    logic        [PTR_W-1:0]               w_grant_idx;
    logic        [NUM_ENGINES-1:0]         w_grant;
    logic                                  w_issue;
    logic                                  w_last_pixel;

    // Engine index (base + offs) folded back into 0..NUM_ENGINES-1.
    function automatic logic [PTR_W-1:0] wrap_idx(input int base, input int offs);
        int s;
        s = base + offs;
        if (s >= NUM_ENGINES) s = s - NUM_ENGINES;
        return PTR_W'(s);
    endfunction

    // NOTE: r_engine_sel is zero whenever the previous edge issued nothing, so it
    // doubles as the "granted at the previous edge" mask without extra state.
    assign w_eligible = engine_idle & ~r_engine_sel;

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (!w_found && w_eligible[wrap_idx(int'(r_rr_ptr), i)]) begin
                w_found     = 1'b1;
                w_grant_idx = wrap_idx(int'(r_rr_ptr), i);
            end
        end
    end

    assign w_grant      = w_found ? (NUM_ENGINES'(1) << w_grant_idx) : '0;
    assign w_issue      = (r_state == S_SCAN) && !full_queue && w_found;
    assign w_last_pixel = (r_scan_x == X_LAST) && (r_scan_y == Y_LAST);

    // NOTE: state is updated with non-blocking assignments only, so every
    // right-hand side below sees the values from before this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_scan_x     <= '0;
            r_scan_y     <= '0;
            r_rr_ptr     <= '0;
            r_pix_valid  <= 1'b0;
            r_pixel_x    <= '0;
            r_pixel_y    <= '0;
            r_engine_sel <= '0;
            r_x_offset   <= '0;
            r_y_offset   <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_pix_valid  <= w_issue;
            r_engine_sel <= w_issue ? w_grant : '0;
            r_frame_done <= 1'b0;

            if (w_issue) begin
                r_pixel_x <= r_scan_x;
                r_pixel_y <= r_scan_y;
                r_rr_ptr  <= wrap_idx(int'(w_grant_idx), 1);
                if (r_scan_x == X_LAST) begin
                    r_scan_x <= '0;
                    r_scan_y <= w_last_pixel ? '0 : r_scan_y + 1'b1;
                end else begin
                    r_scan_x <= r_scan_x + 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_x_offset <= x_offset_in;
                        r_y_offset <= y_offset_in;
                        r_scan_x   <= '0;
                        r_scan_y   <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_issue && w_last_pixel) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // Hold the frame open until every engine has finished its pixel.
                    if (&engine_idle) begin
                        r_frame_done <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pix_valid  = r_pix_valid;
    assign pixel_x    = r_pixel_x;
    assign pixel_y    = r_pixel_y;
    assign engine_sel = r_engine_sel;
    assign x_offset   = r_x_offset;
    assign y_offset   = r_y_offset;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler: a pixel-count reference model predicts
// each issue and frame phase; a negedge monitor pops and compares.
module tb_frame_scheduler;

    localparam int W   = 4;
    localparam int H   = 2;
    localparam int N   = 2;
    localparam int PDW = 10;
    localparam int EDW = 25;
    localparam int FRAME_LIMIT = 200;

    localparam int M_BASIC  = 0;
    localparam int M_BP     = 1;
    localparam int M_SCARCE = 2;
    localparam int M_RANDOM = 3;

    typedef enum int {P_IDLE, P_SCAN, P_DRAIN, P_DONE} phase_t;
    typedef struct {
        int x;
        int y;
        int sel;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  frame_start = 1'b0;
    logic signed [EDW-1:0] x_offset_in = '0;
    logic signed [EDW-1:0] y_offset_in = '0;
    logic                  full_queue = 1'b0;
    logic [N-1:0]          engine_idle = '1;
    logic                  pix_valid;
    logic [PDW-1:0]        pixel_x;
    logic [PDW-1:0]        pixel_y;
    logic [N-1:0]          engine_sel;
    logic signed [EDW-1:0] x_offset;
    logic signed [EDW-1:0] y_offset;
    logic                  busy;
    logic                  frame_done;

    frame_scheduler #(
        .PIXEL_DATA_WIDTH (PDW),
        .ENGINE_DATA_WIDTH(EDW),
        .SCREEN_WIDTH     (W),
        .SCREEN_HEIGHT    (H),
        .NUM_ENGINES      (N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .x_offset_in(x_offset_in),
        .y_offset_in(y_offset_in),
        .full_queue (full_queue),
        .engine_idle(engine_idle),
        .pix_valid  (pix_valid),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .engine_sel (engine_sel),
        .x_offset   (x_offset),
        .y_offset   (y_offset),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase, issue count and round-robin pointer as plain integers.
    exp_t                  exp_q[$];
    phase_t                m_phase = P_IDLE;
    int                    m_n = 0;
    int                    m_ptr = 0;
    int                    m_prev = -1;
    logic signed [EDW-1:0] m_xo = '0;
    logic signed [EDW-1:0] m_yo = '0;

    initial begin : model
        int   grant;
        int   e;
        int   idle_i;
        exp_t item;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_phase = P_IDLE;
                m_n     = 0;
                m_ptr   = 0;
                m_prev  = -1;
                m_xo    = '0;
                m_yo    = '0;
                exp_q.delete();
            end else begin
                grant  = -1;
                idle_i = int'(engine_idle);
                case (m_phase)
                    P_IDLE: if (frame_start) begin
                        m_xo    = x_offset_in;
                        m_yo    = y_offset_in;
                        m_n     = 0;
                        m_phase = P_SCAN;
                    end
                    P_SCAN: if (!full_queue) begin
                        for (int k = 0; k < N; k++) begin
                            e = (m_ptr + k) % N;
                            if (grant < 0 && ((idle_i >> e) & 1) == 1 && e != m_prev) grant = e;
                        end
                        if (grant >= 0) begin
                            item.x   = m_n % W;
                            item.y   = m_n / W;
                            item.sel = 1 << grant;
                            exp_q.push_back(item);
                            m_ptr = (grant + 1) % N;
                            m_n++;
                            if (m_n == W * H) m_phase = P_DRAIN;
                        end
                    end
                    P_DRAIN: if (idle_i == (1 << N) - 1) m_phase = P_DONE;
                    P_DONE:  m_phase = P_IDLE;
                    default: m_phase = P_IDLE;
                endcase
                m_prev = grant;
            end
        end
    end

    int frame_issues = 0;
    int done_cnt     = 0;

    initial begin : monitor
        exp_t got;
        forever begin
            @(negedge clk);
            if (!reset) begin
                frame_issues = 0;
            end else begin
                check("busy", int'(busy), int'(m_phase != P_IDLE));
                check("frame_done", int'(frame_done), int'(m_phase == P_DONE));
                check("x_offset", int'(x_offset), int'(m_xo));
                check("y_offset", int'(y_offset), int'(m_yo));
                if (pix_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_issue", 1, 0);
                    end else begin
                        got = exp_q.pop_front();
                        check("pixel_x", int'(pixel_x), got.x);
                        check("pixel_y", int'(pixel_y), got.y);
                        check("engine_sel", int'(engine_sel), got.sel);
                    end
                    frame_issues++;
                end else begin
                    check("sel_without_valid", int'(engine_sel), 0);
                end
                if (frame_done) begin
                    check("issues_per_frame", frame_issues, W * H);
                    check("queue_drained", exp_q.size(), 0);
                    frame_issues = 0;
                    done_cnt++;
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_pix_valid"}, int'(pix_valid), 0);
        check({tag, "_pixel_x"}, int'(pixel_x), 0);
        check({tag, "_pixel_y"}, int'(pixel_y), 0);
        check({tag, "_engine_sel"}, int'(engine_sel), 0);
        check({tag, "_x_offset"}, int'(x_offset), 0);
        check({tag, "_y_offset"}, int'(y_offset), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
    endtask

    task automatic run_frame(input int mode);
        int  start;
        int  stall;
        int  hold;
        bit  bp_used;
        bit  mid_done;
        bit  finished;
        start    = done_cnt;
        stall    = 0;
        hold     = 0;
        bp_used  = 1'b0;
        mid_done = 1'b0;
        finished = 1'b0;
        @(negedge clk);
        #1;
        frame_start = 1'b1;
        full_queue  = 1'b0;
        if (mode == M_RANDOM) begin
            x_offset_in = EDW'($urandom);
            y_offset_in = EDW'($urandom);
        end else begin
            x_offset_in = 25'h1F00000;
            y_offset_in = 25'h0080000;
        end
        engine_idle = (mode == M_SCARCE) ? N'(1) : '1;
        for (int c = 0; c < FRAME_LIMIT; c++) begin
            @(negedge clk);
            #1;
            if (done_cnt != start) begin
                finished = 1'b1;
                break;
            end
            frame_start = 1'b0;
            case (mode)
                M_BP: begin
                    if (frame_issues == 3 && !bp_used) begin
                        stall   = 3;
                        bp_used = 1'b1;
                    end
                    full_queue = (stall > 0);
                    if (stall > 0) stall--;
                end
                M_SCARCE: begin
                    if (frame_issues == 4 && !mid_done) begin
                        x_offset_in = EDW'($urandom);
                        frame_start = 1'b1;
                        mid_done    = 1'b1;
                    end
                    if (frame_issues == W * H) hold++;
                    engine_idle = (hold > 5) ? '1 : N'(1);
                end
                M_RANDOM: begin
                    engine_idle = N'($urandom);
                    full_queue  = ($urandom_range(0, 3) == 0);
                    frame_start = ($urandom_range(0, 7) == 0);
                    x_offset_in = EDW'($urandom);
                end
                default: begin
                    engine_idle = '1;
                    full_queue  = 1'b0;
                end
            endcase
        end
        frame_start = 1'b0;
        full_queue  = 1'b0;
        engine_idle = '1;
        check("frame_completed", int'(finished), 1);
    endtask

    initial begin : stimulus
        int  start;
        bit  reached;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;

        run_frame(M_BASIC);
        run_frame(M_BP);
        run_frame(M_SCARCE);

        // Abort a frame after five issues with an asynchronous reset.
        start   = done_cnt;
        reached = 1'b0;
        @(negedge clk);
        #1;
        frame_start = 1'b1;
        x_offset_in = 25'h0123456;
        y_offset_in = 25'h1ABCDEF;
        for (int c = 0; c < FRAME_LIMIT; c++) begin
            @(negedge clk);
            #1;
            frame_start = 1'b0;
            if (frame_issues >= 5) begin
                reached = 1'b1;
                break;
            end
        end
        check("reached_five_issues", int'(reached), 1);
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b1;
        check("no_done_after_abort", done_cnt, start);

        run_frame(M_BASIC);
        for (int f = 0; f < 6; f++) run_frame(M_RANDOM);
        run_frame(M_SCARCE);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
